// File: rtl/pipeline_mem_arbiter_if.sv
// rtl/pipeline_mem_arbiter_if.sv - request/ack memory port bundle shared by fetch, data and memory sides
// The master issues req/we/addr/wdata and waits for a one-cycle ack carrying rdata.
interface pipeline_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// rtl/pipeline_mem_arbiter.sv - fetch/data arbiter in front of one single-port memory
// Optional fetch starvation guard is enabled with `define STARVE_GUARD_EN.
module pipeline_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   if_flush,
   pipeline_mem_arbiter_if.slave  fi,
   pipeline_mem_arbiter_if.slave  dm,
   pipeline_mem_arbiter_if.master mem
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } state_t;

   state_t            state_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              if_ack_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic              dm_ack_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              drop_q;

   logic if_elig;
   logic force_if;
   logic grant_if;
   logic grant_dm;

   // A port acknowledged this cycle is still showing its old request, so it cannot win.
   assign if_elig  = fi.req & ~if_flush & ~if_ack_q;
   assign grant_if = (state_q == IDLE) & if_elig & (~dm.req | force_if);
   assign grant_dm = (state_q == IDLE) & dm.req & ~dm_ack_q & ~force_if;

`ifdef STARVE_GUARD_EN
   localparam int STARVE_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

   logic [STARVE_W-1:0] starve_q;

   assign force_if = if_elig & (starve_q == STARVE_W'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_q <= '0;
      end else if (grant_if || !fi.req) begin
         starve_q <= '0;
      end else if (grant_dm && !if_flush && (starve_q < STARVE_W'(STARVE_MAX))) begin
         starve_q <= starve_q + 1'b1;
      end
   end
`else
   localparam int unused_starve_max = STARVE_MAX;

   assign force_if = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_ack_q    <= 1'b0;
         dm_rdata_q  <= '0;
         drop_q      <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               if (grant_dm) begin
                  state_q     <= DM_BUSY;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= dm.we;
                  mem_addr_q  <= dm.addr;
                  mem_wdata_q <= dm.wdata;
               end else if (grant_if) begin
                  state_q     <= IF_BUSY;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= fi.addr;
                  mem_wdata_q <= '0;
               end
            end
            IF_BUSY: begin
               if (if_flush) begin
                  drop_q <= 1'b1;
               end
               // A flushed fetch still has to finish on the bus; only its result is discarded.
               if (mem.ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= IDLE;
                  drop_q    <= 1'b0;
                  if (!(drop_q || if_flush)) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem.rdata;
                  end
               end
            end
            DM_BUSY: begin
               if (mem.ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= IDLE;
                  dm_ack_q  <= 1'b1;
                  if (!mem_we_q) begin
                     dm_rdata_q <= mem.rdata;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem.req   = mem_req_q;
   assign mem.we    = mem_we_q;
   assign mem.addr  = mem_addr_q;
   assign mem.wdata = mem_wdata_q;

   assign fi.ack   = if_ack_q;
   assign fi.rdata = if_rdata_q;
   assign dm.ack   = dm_ack_q;
   assign dm.rdata = dm_rdata_q;

   logic unused_fetch_bits;
   assign unused_fetch_bits = ^{fi.we, fi.wdata};

endmodule
